// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time image loader and fetch-port arbiter for instruction RAM
//
// Accepts a byte stream: two length bytes (word count, big-endian), 4*len data
// bytes forming big-endian words written to instruction RAM from index 0, then
// one XOR checksum byte over the data bytes. The CPU is held in reset until a
// load verifies; after that the RAM address port follows the PC.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   rx_data/valid/ready   byte stream in (handshake = rx_valid & rx_ready)
//   reload                one-cycle request to reload, only acted on in RUN
//   pc_address            fetch byte address from the PC
//   imem_addr             instruction RAM address port
//   imem_we/waddr/wdata   instruction RAM write port (registered)
//   cpu_reset             holds the pipeline in reset
//   load_done             image loaded and checksum verified
//   load_error            last load attempt failed

module imem_loader #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   input  logic                  reload,
   input  logic [31:0]           pc_address,
   output logic [31:0]           imem_addr,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_waddr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_reset,
   output logic                  load_done,
   output logic                  load_error
);

   typedef enum logic [2:0] {
      LEN_HI,
      LEN_LO,
      DATA,
      CHECK,
      RUN
   } state_t;

   localparam logic [31:0] LEN_MAX = 32'd1 << ADDR_WIDTH;

   state_t                state_q, state_d;
   logic [15:0]           len_q, len_d;
   logic [23:0]           word_q, word_d;       // first three bytes of the word in flight
   logic [1:0]            byte_cnt_q, byte_cnt_d;
   logic [ADDR_WIDTH:0]   widx_q, widx_d;       // one extra bit so a full RAM never wraps
   logic [7:0]            xor_q, xor_d;
   logic                  imem_we_q, imem_we_d;
   logic [ADDR_WIDTH-1:0] imem_waddr_q, imem_waddr_d;
   logic [31:0]           imem_wdata_q, imem_wdata_d;
   logic                  load_error_q, load_error_d;

   logic                  accept;
   logic [31:0]           len_new;
   logic                  last_word;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= LEN_HI;
         len_q        <= '0;
         word_q       <= '0;
         byte_cnt_q   <= '0;
         widx_q       <= '0;
         xor_q        <= '0;
         imem_we_q    <= 1'b0;
         imem_waddr_q <= '0;
         imem_wdata_q <= '0;
         load_error_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         word_q       <= word_d;
         byte_cnt_q   <= byte_cnt_d;
         widx_q       <= widx_d;
         xor_q        <= xor_d;
         imem_we_q    <= imem_we_d;
         imem_waddr_q <= imem_waddr_d;
         imem_wdata_q <= imem_wdata_d;
         load_error_q <= load_error_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      word_d       = word_q;
      byte_cnt_d   = byte_cnt_q;
      widx_d       = widx_q;
      xor_d        = xor_q;
      imem_we_d    = 1'b0;
      imem_waddr_d = imem_waddr_q;
      imem_wdata_d = imem_wdata_q;
      load_error_d = load_error_q;

      rx_ready  = (state_q != RUN);
      accept    = rx_valid & rx_ready;
      len_new   = {16'd0, len_q[15:8], rx_data};
      last_word = (32'(widx_q) == ({16'd0, len_q} - 32'd1));

      case (state_q)
         LEN_HI: begin
            if (accept) begin
               len_d[15:8]  = rx_data;
               load_error_d = 1'b0;
               state_d      = LEN_LO;
            end
         end
         LEN_LO: begin
            if (accept) begin
               len_d[7:0] = rx_data;
               // Lengths beyond RAM capacity are rejected up front so the
               // write index can never run past the last word.
               if (len_new == 32'd0 || len_new > LEN_MAX) begin
                  load_error_d = 1'b1;
                  state_d      = LEN_HI;
               end else begin
                  widx_d     = '0;
                  byte_cnt_d = '0;
                  xor_d      = '0;
                  state_d    = DATA;
               end
            end
         end
         DATA: begin
            if (accept) begin
               word_d     = {word_q[15:0], rx_data};
               xor_d      = xor_q ^ rx_data;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  imem_we_d    = 1'b1;
                  imem_waddr_d = widx_q[ADDR_WIDTH-1:0];
                  imem_wdata_d = {word_q, rx_data};
                  widx_d       = widx_q + 1'b1;
                  if (last_word) begin
                     state_d = CHECK;
                  end
               end
            end
         end
         CHECK: begin
            if (accept) begin
               if (rx_data == xor_q) begin
                  state_d = RUN;
               end else begin
                  load_error_d = 1'b1;
                  state_d      = LEN_HI;
               end
            end
         end
         RUN: begin
            if (reload) begin
               load_error_d = 1'b0;
               state_d      = LEN_HI;
            end
         end
         default: state_d = LEN_HI;
      endcase
   end

   assign imem_we    = imem_we_q;
   assign imem_waddr = imem_waddr_q;
   assign imem_wdata = imem_wdata_q;
   assign load_error = load_error_q;
   assign cpu_reset  = (state_q != RUN);
   assign load_done  = (state_q == RUN);
   assign imem_addr  = (state_q == RUN) ? pc_address : 32'({imem_waddr_q, 2'b00});

endmodule
